// File: rtl/system_acl_iface_dipsw_debounce_pkg.sv
// Shared types for the DIP-switch debounce slice.
package system_acl_iface_dipsw_debounce_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/system_acl_iface_debounce_chan.sv
// One debounce channel: counts shared ticks of sustained disagreement before flipping.
module system_acl_iface_debounce_chan
  import system_acl_iface_dipsw_debounce_pkg::*;
#(
  parameter int   STABLE_TICKS = 20,
  parameter logic RESET_BIT    = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_bit,
  input  logic tick,
  output logic out_bit,
  output logic pulse,
  output logic settling
);

  localparam int CNT_W = $clog2(STABLE_TICKS + 1);

  deb_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;

  assign mismatch = sync_bit != out_bit;
  assign settling = cnt != '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_STABLE;
      cnt     <= '0;
      out_bit <= RESET_BIT;
      pulse   <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        ST_STABLE: begin
          if (mismatch && tick) begin
            if (STABLE_TICKS == 1) begin
              out_bit <= sync_bit;
              pulse   <= 1'b1;
            end else begin
              cnt   <= CNT_W'(1);
              state <= ST_SETTLING;
            end
          end
        end
        ST_SETTLING: begin
          // Any bounce back to the current level restarts the qualification.
          if (!mismatch) begin
            cnt   <= '0;
            state <= ST_STABLE;
          end else if (tick) begin
            if (cnt == CNT_W'(STABLE_TICKS - 1)) begin
              out_bit <= sync_bit;
              pulse   <= 1'b1;
              cnt     <= '0;
              state   <= ST_STABLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_STABLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/system_acl_iface_dipsw_debounce.sv
// DIP-switch conditioning: 2-FF synchroniser, shared tick prescaler, per-bit debounce.
module system_acl_iface_dipsw_debounce
  import system_acl_iface_dipsw_debounce_pkg::*;
#(
  parameter int               WIDTH        = 4,
  parameter int               TICK_DIV     = 50000,
  parameter int               STABLE_TICKS = 20,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] change_pulse,
  output logic [WIDTH-1:0] settling
);

  localparam int PCNT_W = $clog2(TICK_DIV + 1);

  logic [WIDTH-1:0]  sync1, sync2;
  logic [PCNT_W-1:0] pcnt;
  logic              tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  end

  // With TICK_DIV == 1 pcnt sits at 0 and tick is permanently high.
  assign tick = pcnt == PCNT_W'(TICK_DIV - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + PCNT_W'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    system_acl_iface_debounce_chan #(
      .STABLE_TICKS (STABLE_TICKS),
      .RESET_BIT    (RESET_VALUE[i])
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .sync_bit (sync2[i]),
      .tick     (tick),
      .out_bit  (out_port[i]),
      .pulse    (change_pulse[i]),
      .settling (settling[i])
    );
  end

endmodule

// File: tb/tb_system_acl_iface_dipsw_debounce.sv
// Scoreboard bench for the DIP-switch debouncer (WIDTH=4, TICK_DIV=4, STABLE_TICKS=3).
module tb_system_acl_iface_dipsw_debounce;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] sw_in = 4'h0;
  logic [3:0] out_port, change_pulse, settling;

  system_acl_iface_dipsw_debounce #(
    .WIDTH(4), .TICK_DIV(4), .STABLE_TICKS(3), .RESET_VALUE(4'h0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw_in(sw_in),
    .out_port(out_port), .change_pulse(change_pulse), .settling(settling)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic [3:0] pulse;
    logic [3:0] outv;
    int         lo;
    int         hi;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Step seen at sw_in now: flip lands 2 sync cycles + 9..12 qualification cycles later.
  task automatic expect_flip(input string name, input logic [3:0] p, input logic [3:0] o);
    exp_t e;
    e.name = name; e.pulse = p; e.outv = o;
    e.lo = cyc + 11; e.hi = cyc + 14;
    q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending pulses want 0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && change_pulse !== 4'h0) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: got %h want none (out_port %h)", change_pulse, out_port);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.name, "_pulse"}, 32'(change_pulse), 32'(e.pulse));
          chk({e.name, "_out"}, 32'(out_port), 32'(e.outv));
          checks++;
          if (cyc < e.lo || cyc > e.hi) begin
            errors++;
            $display("FAIL %s_latency: got cycle %0d want %0d..%0d", e.name, cyc, e.lo, e.hi);
          end
        end
      end
    end
  end

  initial begin
    logic seen;

    // 1: reset with all switches on
    sw_in = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(out_port), 32'h0);
    chk("rst_pulse", 32'(change_pulse), 32'h0);
    chk("rst_settling", 32'(settling), 32'h0);
    reset_n = 1'b1;
    expect_flip("rst_release", 4'hF, 4'hF);
    drain("rst_release");
    sw_in = 4'h0;
    expect_flip("clear_all", 4'hF, 4'h0);
    drain("clear_all");

    // 2: clean step on bit 0
    sw_in = 4'h1;
    expect_flip("step0", 4'h1, 4'h1);
    drain("step0");

    // 3: bounce on bit 1, then settle high
    sw_in = 4'h3; repeat (2) @(negedge clk);
    sw_in = 4'h1; repeat (2) @(negedge clk);
    sw_in = 4'h3; repeat (2) @(negedge clk);
    sw_in = 4'h1; repeat (2) @(negedge clk);
    sw_in = 4'h3;
    expect_flip("bounce1", 4'h2, 4'h3);
    drain("bounce1");

    // 4: 5-cycle glitch on bit 2
    seen = 1'b0;
    sw_in = 4'h7;
    repeat (5) begin @(negedge clk); seen |= settling[2]; end
    sw_in = 4'h3;
    repeat (5) begin @(negedge clk); seen |= settling[2]; end
    repeat (20) @(negedge clk);
    chk("glitch_settled_seen", 32'(seen), 32'h1);
    chk("glitch_settling", 32'(settling), 32'h0);
    chk("glitch_out", 32'(out_port), 32'h3);

    // 5: simultaneous flip 0 -> A
    sw_in = 4'h0;
    expect_flip("clr5", 4'h3, 4'h0);
    drain("clr5");
    sw_in = 4'hA;
    expect_flip("simul", 4'hA, 4'hA);
    drain("simul");

    // 6: async reset while bit 3 is settling
    sw_in = 4'h2;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = settling[3]; end
    chk("pre_reset_settling3", 32'(seen), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(out_port), 32'h0);
    chk("async_rst_pulse", 32'(change_pulse), 32'h0);
    chk("async_rst_settling", 32'(settling), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    expect_flip("rerelease", 4'h2, 4'h2);
    drain("rerelease");
    repeat (20) @(negedge clk);
    chk("final_out", 32'(out_port), 32'h2);
    chk("final_queue", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
